// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - scene encoding, pixel widths and fade helper for screen_controller
package screen_pkg;

    typedef enum logic [1:0] {
        SC_START = 2'd0,
        SC_PLAY  = 2'd1,
        SC_OVER  = 2'd2
    } scene_e;

    localparam int RGB_W      = 24;
    localparam int FADE_STEPS = 8;

    function automatic logic [RGB_W-1:0] fade_rgb(input logic [RGB_W-1:0] rgb,
                                                  input logic [2:0]       sh);
        return {rgb[23:16] >> sh, rgb[15:8] >> sh, rgb[7:0] >> sh};
    endfunction

endpackage

// File: rtl/screen_controller_if.sv
// rtl/screen_controller_if.sv - video timing, renderer inputs and pixel outputs of screen_controller
interface screen_controller_if;
    import screen_pkg::*;

    logic             frame_start;
    logic             visible;
    logic [RGB_W-1:0] start_rgb;
    logic [RGB_W-1:0] game_rgb;
    logic [RGB_W-1:0] over_rgb;
    logic [7:0]       r;
    logic [7:0]       g;
    logic [7:0]       b;

    modport master (
        output frame_start, visible, start_rgb, game_rgb, over_rgb,
        input  r, g, b
    );

    modport slave (
        input  frame_start, visible, start_rgb, game_rgb, over_rgb,
        output r, g, b
    );

endinterface

// File: rtl/screen_controller_btn_sync_edge.sv
// rtl/screen_controller_btn_sync_edge.sv - 2-flop synchroniser with rising-edge pulse
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/screen_controller.sv
// rtl/screen_controller.sv - START/PLAY/OVER scene sequencer and registered pixel mux
// Optional SCREEN_FADE_EN: per-scene fade-in over the first FADE_STEPS frames.
module screen_controller
    import screen_pkg::*;
#(
    parameter int OVER_FRAMES = 180,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_start,
    input  logic                game_over,
    screen_controller_if.slave  pix,
    output scene_e              scene,
    output logic                game_active
);

    scene_e           scene_q, scene_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_req_q, start_req_d;
    logic             over_req_q, over_req_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [RGB_W-1:0] sel_rgb;
    logic             btn_edge;
    logic             start_evt;
    logic             over_evt;

    btn_sync_edge u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_start),
        .pulse (btn_edge)
    );

    always_comb begin
        // Events arriving on the frame_start cycle still belong to the ending frame.
        start_evt   = start_req_q | btn_edge;
        over_evt    = over_req_q | game_over;
        scene_d     = scene_q;
        start_req_d = pix.frame_start ? 1'b0 : start_evt;
        over_req_d  = pix.frame_start ? 1'b0 : over_evt;

        if (pix.frame_start) begin
            case (scene_q)
                SC_START: if (start_evt) scene_d = SC_PLAY;
                SC_PLAY:  if (over_evt)  scene_d = SC_OVER;
                SC_OVER: begin
                    if (start_evt)
                        scene_d = SC_PLAY;
                    else if (cnt_q == CNT_W'(OVER_FRAMES - 1))
                        scene_d = SC_START;
                end
                default:  scene_d = SC_START;
            endcase
        end

        cnt_d = cnt_q;
        if (scene_d != scene_q)
            cnt_d = '0;
        else if (pix.frame_start && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);

        case (scene_q)
            SC_START: sel_rgb = pix.start_rgb;
            SC_PLAY:  sel_rgb = pix.game_rgb;
            SC_OVER:  sel_rgb = pix.over_rgb;
            default:  sel_rgb = '0;
        endcase

`ifdef SCREEN_FADE_EN
        // Below FADE_STEPS, 7-cnt equals the bitwise inverse of the low three bits.
        if (cnt_q < CNT_W'(FADE_STEPS))
            sel_rgb = fade_rgb(sel_rgb, ~cnt_q[2:0]);
`endif

        rgb_d = pix.visible ? sel_rgb : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scene_q     <= SC_START;
            cnt_q       <= '0;
            start_req_q <= 1'b0;
            over_req_q  <= 1'b0;
            rgb_q       <= '0;
        end else begin
            scene_q     <= scene_d;
            cnt_q       <= cnt_d;
            start_req_q <= start_req_d;
            over_req_q  <= over_req_d;
            rgb_q       <= rgb_d;
        end
    end

    assign pix.r       = rgb_q[23:16];
    assign pix.g       = rgb_q[15:8];
    assign pix.b       = rgb_q[7:0];
    assign scene       = scene_q;
    assign game_active = (scene_q == SC_PLAY);

endmodule

// File: tb/tb_screen_controller.sv
// tb/tb_screen_controller.sv - directed vector bench for screen_controller
module tb_screen_controller;
    import screen_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   btn_start;
    logic   game_over;
    scene_e scene;
    logic   game_active;
    int     total = 0;
    int     bad   = 0;

    screen_controller_if pif ();

    screen_controller #(.OVER_FRAMES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_start   (btn_start),
        .game_over   (game_over),
        .pix         (pif),
        .scene       (scene),
        .game_active (game_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vis;
        logic [23:0] srgb;
        logic [23:0] exp;
    } vec_t;

    vec_t       vt [6];
    logic [7:0] fexp [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        pif.frame_start = 1'b1;
        step();
        pif.frame_start = 1'b0;
    endtask

    task automatic press();
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(4);
    endtask

    task automatic over_pulse();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        step();
    endtask

    function automatic logic [23:0] fx(input logic [23:0] v, input int n);
        logic [23:0] o;
        o = v;
`ifdef SCREEN_FADE_EN
        if (n < 8) begin
            o[23:16] = v[23:16] >> (7 - n);
            o[15:8]  = v[15:8]  >> (7 - n);
            o[7:0]   = v[7:0]   >> (7 - n);
        end
`endif
        return o;
    endfunction

    function automatic logic [31:0] rgb_now();
        return {8'h00, pif.r, pif.g, pif.b};
    endfunction

    initial begin
        vt[0] = '{1'b1, 24'h00FF00, 24'h00FF00};
        vt[1] = '{1'b0, 24'hFFFFFF, 24'h000000};
        vt[2] = '{1'b1, 24'hFFFFFF, 24'hFFFFFF};
        vt[3] = '{1'b1, 24'h010203, 24'h010203};
        vt[4] = '{1'b0, 24'h00FF00, 24'h000000};
        vt[5] = '{1'b1, 24'hA5C3E1, 24'hA5C3E1};
`ifdef SCREEN_FADE_EN
        fexp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h80};
`else
        fexp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
`endif

        rst_n           = 1'b0;
        btn_start       = 1'b0;
        game_over       = 1'b0;
        pif.frame_start = 1'b0;
        pif.visible     = 1'b1;
        pif.start_rgb   = 24'h00FF00;
        pif.game_rgb    = 24'h123456;
        pif.over_rgb    = 24'hABCDEF;
        step(3);
        chk("reset_rgb", rgb_now(), 32'h0);
        chk("reset_scene", 32'(scene), 32'(SC_START));
        chk("reset_active", 32'(game_active), 32'h0);

        rst_n = 1'b1;
        step();
        chk("release_rgb", rgb_now(), 32'(fx(24'h00FF00, 0)));

        for (int i = 0; i < 6; i++) begin
            pif.visible   = vt[i].vis;
            pif.start_rgb = vt[i].srgb;
            step();
            chk($sformatf("vec%0d_rgb", i), rgb_now(), 32'(fx(vt[i].exp, 0)));
            chk($sformatf("vec%0d_scene", i), 32'(scene), 32'(SC_START));
        end

        pif.visible   = 1'b1;
        pif.start_rgb = 24'h00FF00;
        btn_start = 1'b1;
        step(5);
        btn_start = 1'b0;
        step(5);
        chk("btn_mid_frame", 32'(scene), 32'(SC_START));
        frame();
        chk("btn_to_play", 32'(scene), 32'(SC_PLAY));
        chk("play_active", 32'(game_active), 32'h1);
        chk("sel_old_scene", rgb_now(), 32'(fx(24'h00FF00, 0)));
        step();
        chk("game_rgb", rgb_now(), 32'(fx(24'h123456, 0)));
        frame();
        chk("play_hold", 32'(scene), 32'(SC_PLAY));

        over_pulse();
        step(3);
        chk("over_waits_frame", 32'(scene), 32'(SC_PLAY));
        frame();
        chk("to_over", 32'(scene), 32'(SC_OVER));
        chk("over_inactive", 32'(game_active), 32'h0);
        for (int k = 0; k < 3; k++) begin
            frame();
            chk($sformatf("over_stay%0d", k), 32'(scene), 32'(SC_OVER));
        end
        frame();
        chk("over_timeout", 32'(scene), 32'(SC_START));

        over_pulse();
        frame();
        chk("over_ignored_start", 32'(scene), 32'(SC_START));
        press();
        frame();
        chk("restart_play", 32'(scene), 32'(SC_PLAY));
        frame();
        chk("over_req_cleared", 32'(scene), 32'(SC_PLAY));

        game_over       = 1'b1;
        pif.frame_start = 1'b1;
        step();
        game_over       = 1'b0;
        pif.frame_start = 1'b0;
        chk("evt_same_cycle", 32'(scene), 32'(SC_OVER));

        for (int k = 0; k < 3; k++) frame();
        chk("over_before_tmo", 32'(scene), 32'(SC_OVER));
        press();
        frame();
        chk("restart_priority", 32'(scene), 32'(SC_PLAY));

        pif.game_rgb = 24'h808080;
        for (int n = 0; n < 9; n++) begin
            step();
            chk($sformatf("fade%0d_r", n), 32'(pif.r), 32'(fexp[n]));
            frame();
        end

        pif.visible  = 1'b0;
        pif.game_rgb = 24'hFFFFFF;
        step();
        chk("invisible_black", rgb_now(), 32'h0);
        pif.visible = 1'b1;
        step();
        chk("pre_reset_play", 32'(scene), 32'(SC_PLAY));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_scene", 32'(scene), 32'(SC_START));
        chk("async_reset_rgb", rgb_now(), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
